// File: rtl/nexys_starship_lane_monsters.sv
// Multi-lane monster manager: LFSR-driven spawning, per-lane expiry timers,
// post-kill spawn cooldown, saturating kill score and INIT/PLAY/OVER game FSM.
module nexys_starship_lane_monsters #(
  parameter int          NUM_LANES    = 4,
  parameter int          TIMER_W      = 8,
  parameter int          TIMEOUT      = 200,
  parameter int          COOLDOWN     = 16,
  parameter int          SPAWN_THRESH = 8,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          SCORE_W      = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 tick,
  input  logic                 play,
  input  logic [NUM_LANES-1:0] kill,
  output logic [NUM_LANES-1:0] lane_full,
  output logic [SCORE_W-1:0]   score,
  output logic                 game_over,
  output logic [2:0]           over_lane,
  output logic                 q_Init,
  output logic                 q_Play,
  output logic                 q_Over
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_e;

  localparam logic [15:0]        SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [7:0]         NL8       = 8'(NUM_LANES);
  localparam logic [8:0]         THR9      = 9'(SPAWN_THRESH);
  localparam logic [TIMER_W-1:0] TO_V      = TIMER_W'(TIMEOUT);
  localparam logic [TIMER_W-1:0] CD_V      = TIMER_W'(COOLDOWN);
  localparam logic [TIMER_W-1:0] ONE_T     = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] ZERO_T    = TIMER_W'(0);
  localparam logic [SCORE_W-1:0] ONE_S     = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  state_e                              state_q, state_d;
  logic [15:0]                         lfsr_q, lfsr_d;
  logic [NUM_LANES-1:0]                full_q, full_d;
  logic [NUM_LANES-1:0][TIMER_W-1:0]   timer_q, timer_d;
  logic [NUM_LANES-1:0][TIMER_W-1:0]   cool_q, cool_d;
  logic [SCORE_W-1:0]                  score_q, score_d;
  logic [2:0]                          over_lane_q, over_lane_d;
  logic                                q_init_q, q_play_q, q_over_q;
  logic [7:0]                          target_s;
  logic [NUM_LANES-1:0]                spawn_s;
  logic                                expired_s;

  // Spawn roll from the pre-advance LFSR; decided on registered lane state only
  always_comb begin
    target_s = lfsr_q[15:8] % NL8;
    spawn_s  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      spawn_s[i] = tick && ({1'b0, lfsr_q[7:0]} < THR9) && (target_s == 8'(i)) &&
                   !full_q[i] && (cool_q[i] == ZERO_T);
    end
  end

  // Next-state logic for the game FSM, lanes, score and LFSR
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    full_d      = full_q;
    timer_d     = timer_q;
    cool_d      = cool_q;
    score_d     = score_q;
    over_lane_d = over_lane_q;
    expired_s   = 1'b0;
    case (state_q)
      S_INIT: begin
        if (play) begin
          state_d = S_PLAY;
          full_d  = '0;
          timer_d = '0;
          cool_d  = '0;
          score_d = '0;
        end else begin
          state_d = S_INIT;
        end
      end
      S_PLAY: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (kill[i] && full_q[i]) begin
            full_d[i] = 1'b0;
            cool_d[i] = CD_V;
            score_d   = (score_d == SCORE_MAX) ? score_d : score_d + ONE_S;
          end else if (tick && full_q[i]) begin
            // Lowest-index expiry is reported; later ones are only noted
            if (timer_q[i] == ONE_T) begin
              over_lane_d = expired_s ? over_lane_d : 3'(i);
              expired_s   = 1'b1;
            end else begin
              timer_d[i] = timer_q[i] - ONE_T;
            end
          end else if (tick && (cool_q[i] != ZERO_T)) begin
            cool_d[i] = cool_q[i] - ONE_T;
          end else begin
            cool_d[i] = cool_d[i];
          end
          if (spawn_s[i]) begin
            full_d[i]  = 1'b1;
            timer_d[i] = TO_V;
          end else begin
            full_d[i] = full_d[i];
          end
        end
        state_d = expired_s ? S_OVER : S_PLAY;
      end
      S_OVER: begin
        state_d = play ? S_INIT : S_OVER;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
    if (tick) begin
      lfsr_d = lfsr_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // State registers and registered one-hot state outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_INIT;
      lfsr_q      <= SEED_EFF;
      full_q      <= '0;
      timer_q     <= '0;
      cool_q      <= '0;
      score_q     <= '0;
      over_lane_q <= 3'd0;
      q_init_q    <= 1'b1;
      q_play_q    <= 1'b0;
      q_over_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      full_q      <= full_d;
      timer_q     <= timer_d;
      cool_q      <= cool_d;
      score_q     <= score_d;
      over_lane_q <= over_lane_d;
      q_init_q    <= (state_d == S_INIT);
      q_play_q    <= (state_d == S_PLAY);
      q_over_q    <= (state_d == S_OVER);
    end
  end

  assign lane_full = full_q;
  assign score     = score_q;
  assign over_lane = over_lane_q;
  assign game_over = q_over_q;
  assign q_Init    = q_init_q;
  assign q_Play    = q_play_q;
  assign q_Over    = q_over_q;

endmodule

// File: tb/tb_nexys_starship_lane_monsters.sv
// Randomized scoreboard bench: an integer-level game model predicts every
// cycle's outputs; a monitor compares them on the falling clock edge.
module tb_nexys_starship_lane_monsters;
  localparam int N    = 4;
  localparam int TW   = 8;
  localparam int TO   = 6;
  localparam int CD   = 2;
  localparam int THR  = 160;
  localparam int SW   = 3;
  localparam int SMAX = (1 << SW) - 1;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          tick = 1'b0;
  logic          play = 1'b0;
  logic [N-1:0]  kill = '0;
  logic [N-1:0]  lane_full;
  logic [SW-1:0] score;
  logic          game_over;
  logic [2:0]    over_lane;
  logic          q_Init, q_Play, q_Over;

  nexys_starship_lane_monsters #(
    .NUM_LANES(N), .TIMER_W(TW), .TIMEOUT(TO), .COOLDOWN(CD),
    .SPAWN_THRESH(THR), .SEED(16'hACE1), .SCORE_W(SW)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .tick(tick), .play(play), .kill(kill),
    .lane_full(lane_full), .score(score), .game_over(game_over),
    .over_lane(over_lane), .q_Init(q_Init), .q_Play(q_Play), .q_Over(q_Over)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [N-1:0]  full;
    logic [SW-1:0] score;
    logic          go;
    logic [2:0]    ol;
    logic          qi, qp, qo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: 0=INIT 1=PLAY 2=OVER
  int          m_state;
  logic [15:0] m_lfsr;
  bit          m_full[N];
  int          m_timer[N];
  int          m_cool[N];
  int          m_score;
  int          m_ol;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_lfsr = 16'hACE1; m_score = 0; m_ol = 0;
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; m_timer[i] = 0; m_cool[i] = 0;
    end
  endtask

  task automatic model_step(input bit t, input bit p, input logic [N-1:0] k);
    bit nf[N];
    int nt[N], nc[N];
    int ns, exp_lane, roll, tgt;
    nf = m_full; nt = m_timer; nc = m_cool; ns = m_state; exp_lane = -1;
    if (m_state == 0) begin
      if (p) begin
        ns = 1; m_score = 0;
        for (int i = 0; i < N; i++) begin nf[i] = 0; nt[i] = 0; nc[i] = 0; end
      end
    end else if (m_state == 1) begin
      for (int i = 0; i < N; i++) begin
        if (k[i] && m_full[i]) begin
          nf[i] = 0; nc[i] = CD;
          if (m_score < SMAX) m_score = m_score + 1;
        end else if (t && m_full[i]) begin
          if (m_timer[i] == 1) begin
            if (exp_lane < 0) exp_lane = i;
          end else nt[i] = m_timer[i] - 1;
        end else if (t && m_cool[i] > 0) nc[i] = m_cool[i] - 1;
      end
      if (t) begin
        roll = int'(m_lfsr[7:0]);
        tgt  = int'(m_lfsr[15:8]) % N;
        if (roll < THR && !m_full[tgt] && m_cool[tgt] == 0) begin
          nf[tgt] = 1; nt[tgt] = TO;
        end
      end
      if (exp_lane >= 0) begin ns = 2; m_ol = exp_lane; end
    end else begin
      if (p) ns = 0;
    end
    if (t) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    m_full = nf; m_timer = nt; m_cool = nc; m_state = ns;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < N; i++) e.full[i] = m_full[i];
    e.score = SW'(m_score);
    e.go    = (m_state == 2);
    e.ol    = 3'(m_ol);
    e.qi    = (m_state == 0);
    e.qp    = (m_state == 1);
    e.qo    = (m_state == 2);
    return e;
  endfunction

  // Drive one cycle of inputs, predict, then advance to just after the next falling edge
  task automatic step(input bit t, input bit p, input logic [N-1:0] k);
    tick = t; play = p; kill = k;
    model_step(t, p, k);
    sb.push_back(model_out());
    @(negedge Clk); #1;
  endtask

  // Monitor: compare whatever the DUT presents against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("lane_full", int'(lane_full), int'(e.full));
        check("score",     int'(score),     int'(e.score));
        check("game_over", int'(game_over), int'(e.go));
        check("over_lane", int'(over_lane), int'(e.ol));
        check("q_Init",    int'(q_Init),    int'(e.qi));
        check("q_Play",    int'(q_Play),    int'(e.qp));
        check("q_Over",    int'(q_Over),    int'(e.qo));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_q_Init"},    int'(q_Init),    1);
    check({tag, "_q_Play"},    int'(q_Play),    0);
    check({tag, "_q_Over"},    int'(q_Over),    0);
    check({tag, "_lane_full"}, int'(lane_full), 0);
    check({tag, "_score"},     int'(score),     0);
    check({tag, "_game_over"}, int'(game_over), 0);
    check({tag, "_over_lane"}, int'(over_lane), 0);
  endtask

  task automatic random_phase(input int cycles);
    int tprob, kprob, kmode;
    logic [N-1:0] k;
    bit t;
    for (int c = 0; c < cycles; c++) begin
      if (c % 250 == 0) begin
        tprob = $urandom_range(20, 100);
        kprob = $urandom_range(0, 40);
      end
      t = ($urandom_range(0, 99) < tprob);
      k = '0;
      if ($urandom_range(0, 99) < kprob) begin
        kmode = $urandom_range(0, 2);
        for (int i = 0; i < N; i++) begin
          case (kmode)
            0: k[i] = $urandom_range(0, 1);
            1: k[i] = m_full[i] && ($urandom_range(0, 1) == 1);
            default: k[i] = t && m_full[i] && (m_timer[i] == 1) && ($urandom_range(0, 3) != 0);
          endcase
        end
      end
      step(t, ($urandom_range(0, 15) == 0), k);
    end
  endtask

  initial begin
    bit any_full;
    model_reset();
    repeat (3) @(negedge Clk);
    #1;
    check_reset_state("por");
    Reset_n = 1'b1;
    random_phase(4000);

    // Reach PLAY with at least one monster, then pull reset between edges
    any_full = 0;
    for (int c = 0; c < 400 && !any_full; c++) begin
      if (m_state == 1) begin
        for (int i = 0; i < N; i++) if (m_full[i]) any_full = 1;
      end
      if (!any_full) step(m_state == 1 ? 1'b1 : 1'($urandom_range(0, 1)), m_state != 1, '0);
    end
    check("midgame_setup", int'(any_full), 1);
    Reset_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    model_reset();
    @(negedge Clk); #1;
    Reset_n = 1'b1;
    random_phase(1500);
    tick = 1'b0; play = 1'b0; kill = '0;
    @(negedge Clk); #2;
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nexys_starship_lane_monsters.md
# nexys_starship_lane_monsters

Parametrised monster manager for Nexys Starship: tracks NUM_LANES independent lanes, each of which can hold one monster. Monsters spawn pseudo-randomly from an internal LFSR, must be shot within a programmable number of game ticks, and an unshot monster ends the game. It generalises the single-lane top-monster controller to N lanes and adds kill handling, spawn cooldown, scoring and restart. It sits between the game-tick/input logic and the display/score logic.

## Interface
- NUM_LANES, 4, number of lanes (2..8)
- TIMER_W, 8, width of per-lane countdown and cooldown counters
- TIMEOUT, 200, ticks a monster survives before the game is lost (1..2^TIMER_W-1)
- COOLDOWN, 16, ticks a lane stays spawn-inhibited after a kill (0..2^TIMER_W-1)
- SPAWN_THRESH, 8, spawn probability per tick in 1/256 units (0 = never)
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1
- SCORE_W, 16, score width
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle game-tick strobe
- play  in  1  start (in INIT) / restart (in OVER) request, level-sampled
- kill  in  NUM_LANES  per-lane shot hit, one-cycle pulses, sampled every cycle
- lane_full  out  NUM_LANES  lane holds a monster
- score  out  SCORE_W  monsters killed this game, saturating
- game_over  out  1  high while in OVER
- over_lane  out  3  lane whose monster expired
- q_Init, q_Play, q_Over  out  1 each  one-hot global state

## Operation
- Reset (Reset_n low): state INIT, lanes empty, all timers/cooldowns 0, score 0, over_lane 0, game_over 0, LFSR = SEED.
- Global FSM: INIT -> PLAY when play=1 (lanes, cooldowns, score cleared on the transition). PLAY -> OVER on any expiry. OVER -> INIT when play=1. No other transitions; illegal encodings go to INIT.
- LFSR: 16-bit Galois, advances once per tick in every state: next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000).
- Spawn (PLAY, tick cycle, using pre-advance LFSR value): roll = lfsr[7:0], target = lfsr[15:8] mod NUM_LANES. Spawn iff roll < SPAWN_THRESH and target lane empty and its cooldown = 0. At most one spawn per tick. Spawn sets lane full and loads timer = TIMEOUT.
- Per-lane update in PLAY, priority order:
  1. kill[i] with lane full: lane empty, cooldown = COOLDOWN, score += 1 (saturating at all-ones). Any cycle.
  2. tick, lane full, timer = 1: expiry.
  3. tick, lane full: timer -= 1.
  4. tick, lane empty, cooldown > 0: cooldown -= 1.
- kill on an empty lane, or outside PLAY: ignored, no score change.
- Kill and expiry in the same cycle on the same lane: kill wins, no expiry.
- Multiple expiries in one tick: over_lane = lowest index; game still ends once.
- Spawn decision uses registered lane state: a lane killed in the same cycle cannot be respawned that cycle.
- In OVER: lanes, score and over_lane frozen; kill and tick have no effect except LFSR advance.

## Timing
- All outputs registered; changes visible the cycle after the causing edge.
- Monster spawned on tick k expires on tick k+TIMEOUT if not killed; kill on any cycle up to and including that tick's cycle prevents it.
- Lane killed at cycle c: spawnable again on the (COOLDOWN+1)-th tick after c (COOLDOWN decrements, then the next tick may spawn).
- play held high: INIT->PLAY after 1 cycle; from OVER takes 2 cycles to reach PLAY (OVER->INIT->PLAY).
- Reset_n assertion mid-game forces reset values immediately (asynchronously); deassertion is synchronised externally.

## Test plan
- Reset: Reset_n low mid-PLAY with lanes full -> q_Init=1, lane_full=0, score=0, game_over=0 without a Clk edge.
- Deterministic spawn: SEED default, SPAWN_THRESH=255, play, 20 ticks -> lane_full sequence matches bit-exact LFSR model; at most one new lane per tick.
- Timeout: SPAWN_THRESH=255, TIMEOUT=3, no kills -> first spawned lane expires exactly 3 ticks after spawn; game_over=1, over_lane = that lane, q_Over=1.
- Kill/cooldown: TIMEOUT=10, COOLDOWN=2, kill full lane 2 -> score 1, lane_full[2]=0, lane 2 never targeted successfully for next 2 ticks.
- Simultaneous: kill[1] in same cycle as lane 1 final tick -> no game_over, score +1; two lanes expiring same tick (lanes 1,3) -> over_lane=1.
- Saturation/restart: SCORE_W=2, 5 kills -> score=3; in OVER, kill pulses leave score unchanged; play -> INIT then PLAY with score 0.
